clk_enable_scheduler: RTL

- Run-time controller for the design's divided clocks.
- Sequences a single programmable divider: start/stop, glitch-free divisor reconfiguration at period boundaries, invalid-config rejection.
- Produces the divided square wave plus a one-cycle tick enable for downstream logic in the in_clk domain (e.g. 25 MHz pixel enable from a 100 MHz board clock).

---
 rtl/clk_enable_scheduler_if.sv | 25 ++
 rtl/clk_enable_scheduler.sv | 117 +++++++++++
 2 files changed

// File: rtl/clk_enable_scheduler_if.sv
// Control/status bundle for clk_enable_scheduler: run request, divisor write
// handshake, and the divided-clock outputs.
interface clk_enable_scheduler_if #(
  parameter int unsigned CNT_W = 28
);
  logic             run;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;
  logic             out_clk;
  logic             tick;
  logic             running;
  logic [CNT_W-1:0] cur_div;

  modport master (
    output run, cfg_valid, cfg_div,
    input  cfg_ready, cfg_err, out_clk, tick, running, cur_div
  );

  modport slave (
    input  run, cfg_valid, cfg_div,
    output cfg_ready, cfg_err, out_clk, tick, running, cur_div
  );
endinterface

// File: rtl/clk_enable_scheduler.sv
// Programmable half-period divider with glitch-free start/stop and divisor
// changes deferred to full-period boundaries; emits a square wave and a tick.
module clk_enable_scheduler #(
  parameter int unsigned CNT_W       = 28,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic                   in_clk,
  input  logic                   reset,
  clk_enable_scheduler_if.slave  bus
);

  localparam logic [1:0] ST_STOP = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [CNT_W-1:0] div_q, div_nxt;
  logic [CNT_W-1:0] pend_q, pend_nxt;
  logic             out_q, out_nxt;
  logic             tick_q, tick_nxt;
  logic             err_q, err_nxt;
  logic             ready_q, ready_nxt;
  logic             running_q, running_nxt;

  logic             accept, wr_ok, wrap, fall;
  logic [CNT_W-1:0] stop_div;

  always_ff @(posedge in_clk) begin
    if (reset) begin
      state     <= ST_STOP;
      count     <= '0;
      div_q     <= CNT_W'(DEFAULT_DIV);
      pend_q    <= '0;
      out_q     <= 1'b0;
      tick_q    <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b1;
      running_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      div_q     <= div_nxt;
      pend_q    <= pend_nxt;
      out_q     <= out_nxt;
      tick_q    <= tick_nxt;
      err_q     <= err_nxt;
      ready_q   <= ready_nxt;
      running_q <= running_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    div_nxt   = div_q;
    pend_nxt  = pend_q;
    out_nxt   = out_q;
    tick_nxt  = 1'b0;

    // ready_q is registered from the next state, so it tracks state != PEND
    accept   = bus.cfg_valid && ready_q;
    wr_ok    = accept && (bus.cfg_div != '0);
    err_nxt  = accept && (bus.cfg_div == '0);
    wrap     = (count == div_q - CNT_W'(1));
    fall     = wrap && out_q;
    // Divisor to install when stopping: a deferred write wins over the current one
    stop_div = (state == ST_PEND) ? pend_q : (wr_ok ? bus.cfg_div : div_q);

    case (state)
      ST_STOP: begin
        count_nxt = '0;
        out_nxt   = 1'b0;
        if (wr_ok) div_nxt = bus.cfg_div;
        if (bus.run) state_nxt = ST_RUN;
      end
      ST_RUN, ST_PEND: begin
        if (!bus.run && !out_q) begin
          state_nxt = ST_STOP;
          count_nxt = '0;
          out_nxt   = 1'b0;
          div_nxt   = stop_div;
        end else begin
          count_nxt = wrap ? '0 : count + CNT_W'(1);
          out_nxt   = wrap ? ~out_q : out_q;
          tick_nxt  = wrap && !out_q;
          if (fall && !bus.run) begin
            state_nxt = ST_STOP;
            div_nxt   = stop_div;
          end else if (fall && (state == ST_PEND)) begin
            state_nxt = ST_RUN;
            div_nxt   = pend_q;
          end else if ((state == ST_RUN) && wr_ok) begin
            state_nxt = ST_PEND;
            pend_nxt  = bus.cfg_div;
          end
        end
      end
      default: begin
        state_nxt = ST_STOP;
        count_nxt = '0;
        out_nxt   = 1'b0;
      end
    endcase

    ready_nxt   = (state_nxt != ST_PEND);
    running_nxt = (state_nxt != ST_STOP);
  end

  assign bus.cfg_ready = ready_q;
  assign bus.cfg_err   = err_q;
  assign bus.out_clk   = out_q;
  assign bus.tick      = tick_q;
  assign bus.running   = running_q;
  assign bus.cur_div   = div_q;

endmodule
